// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD write path: word width, arbiter state
// encoding and default timing constants.
package lcd_pkg;

  localparam int LCD_DATA_W         = 18;
  localparam int LCD_GAP_CYCLES     = 2;
  localparam int LCD_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    GAP     = 3'd4
  } lcd_arb_state_t;

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int lcd_cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_write_arbiter_if.sv
// Requester-side and driver-side signals of the LCD write arbiter.
// The slave modport is the arbiter's view, master is the surrounding system.
interface lcd_write_arbiter_if
  import lcd_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = LCD_DATA_W
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_line;
  logic [NUM_REQ-1:0]        req_set_line;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic                      err;
  logic                      busy;
  logic                      lcd_write;
  logic [DATA_W-1:0]         lcd_data;
  logic                      lcd_line;
  logic                      lcd_set_line;
  logic                      lcd_en;

  modport slave (
    input  req, req_data, req_line, req_set_line, lcd_en,
    output gnt, done, err, busy, lcd_write, lcd_data, lcd_line, lcd_set_line
  );

  modport master (
    output req, req_data, req_line, req_set_line, lcd_en,
    input  gnt, done, err, busy, lcd_write, lcd_data, lcd_line, lcd_set_line
  );

endinterface

// File: rtl/lcd_write_arbiter_rr_pick.sv
// Combinational round-robin finder: first set request bit at or above ptr,
// wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic               any,
  output logic [PW-1:0]      idx
);

  int k;

  always_comb begin
    any = 1'b0;
    idx = '0;
    k   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!any && req[k]) begin
        any = 1'b1;
        idx = PW'(k);
      end
    end
  end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter and write sequencer sharing the LCD_Driver write port:
// latch winner, pulse lcdWrite, follow enableOut high/low with timeout, then gap.
module lcd_write_arbiter
  import lcd_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = LCD_DATA_W,
  parameter int GAP_CYCLES     = LCD_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = LCD_TIMEOUT_CYCLES
) (
  input logic                clk,
  input logic                rst,
  lcd_write_arbiter_if.slave bus
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = lcd_cnt_w(TIMEOUT_CYCLES);

  lcd_arb_state_t state, state_nxt;

  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     owner;
  logic [TW-1:0]     timer;
  logic [3:0]        gap_cnt;
  logic              err_flag;
  logic [DATA_W-1:0] data_q;
  logic              line_q;
  logic              set_line_q;

  logic              pick_any;
  logic [PW-1:0]     pick_idx;
  logic [PW-1:0]     ptr_nxt;
  logic [DATA_W-1:0] pick_data;
  logic              timer_last;
  logic              gap_last;
  logic [NUM_REQ-1:0] owner_oh;

  logic [NUM_REQ-1:0] gnt_c;
  logic [NUM_REQ-1:0] done_c;
  logic               err_c;
  logic               busy_c;
  logic               write_c;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_pick (
    .req (bus.req),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign pick_data  = bus.req_data[int'(pick_idx)*DATA_W +: DATA_W];
  assign ptr_nxt    = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
  assign timer_last = (timer == TW'(TIMEOUT_CYCLES - 1));
  assign gap_last   = (gap_cnt == 4'(GAP_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The enableOut rising edge takes priority over a coincident timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT_HI;
      WAIT_HI: begin
        if (bus.lcd_en)      state_nxt = WAIT_LO;
        else if (timer_last) state_nxt = GAP;
      end
      WAIT_LO: begin
        if (!bus.lcd_en)     state_nxt = GAP;
        else if (timer_last) state_nxt = GAP;
      end
      GAP:     if (gap_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transfer bookkeeping; the latched word is cleared by reset so the driver
  // never sees stale data from an abandoned transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      owner      <= '0;
      timer      <= '0;
      gap_cnt    <= '0;
      err_flag   <= 1'b0;
      data_q     <= '0;
      line_q     <= 1'b0;
      set_line_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            data_q     <= pick_data;
            line_q     <= bus.req_line[pick_idx];
            set_line_q <= bus.req_set_line[pick_idx];
            owner      <= pick_idx;
            rr_ptr     <= ptr_nxt;
          end
        end
        ISSUE: timer <= '0;
        WAIT_HI: begin
          if (bus.lcd_en)      timer    <= '0;
          else if (timer_last) err_flag <= 1'b1;
          else                 timer    <= timer + 1'b1;
        end
        WAIT_LO: begin
          if (!bus.lcd_en)     timer    <= '0;
          else if (timer_last) err_flag <= 1'b1;
          else                 timer    <= timer + 1'b1;
        end
        GAP: begin
          if (gap_last) begin
            gap_cnt  <= '0;
            err_flag <= 1'b0;
          end else begin
            gap_cnt  <= gap_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
    gnt_c           = '0;
    done_c          = '0;
    err_c           = 1'b0;
    write_c         = 1'b0;
    busy_c          = (state != IDLE);
    if (state == ISSUE) begin
      gnt_c   = owner_oh;
      write_c = 1'b1;
    end
    if (state == GAP && gap_last) begin
      done_c = owner_oh;
      err_c  = err_flag;
    end
  end

  assign bus.gnt          = gnt_c;
  assign bus.done         = done_c;
  assign bus.err          = err_c;
  assign bus.busy         = busy_c;
  assign bus.lcd_write    = write_c;
  assign bus.lcd_data     = data_q;
  assign bus.lcd_line     = line_q;
  assign bus.lcd_set_line = set_line_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter with a small LCD_Driver enableOut model.
module tb_lcd_write_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 18;
  localparam int GPC = 2;
  localparam int TO  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_write_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  lcd_write_arbiter #(
    .NUM_REQ        (NR),
    .DATA_W         (DW),
    .GAP_CYCLES     (GPC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver model: enableOut rises one cycle after lcdWrite and stays high en_len cycles.
  logic stuck  = 1'b0;
  int   en_len = 3;
  int   en_cnt = 0;
  always @(negedge clk) begin
    if (en_cnt > 0) begin
      bus.lcd_en = 1'b1;
      en_cnt     = en_cnt - 1;
    end else begin
      bus.lcd_en = 1'b0;
    end
    if (bus.lcd_write && !stuck) en_cnt = en_len;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"},      32'(bus.gnt),          32'h0);
    check({tag, "_done"},     32'(bus.done),         32'h0);
    check({tag, "_err"},      32'(bus.err),          32'h0);
    check({tag, "_busy"},     32'(bus.busy),         32'h0);
    check({tag, "_write"},    32'(bus.lcd_write),    32'h0);
    check({tag, "_data"},     32'(bus.lcd_data),     32'h0);
    check({tag, "_line"},     32'(bus.lcd_line),     32'h0);
    check({tag, "_setline"},  32'(bus.lcd_set_line), 32'h0);
  endtask

  // Raise req and wait (bounded) for the grant; returns in the ISSUE cycle with req dropped.
  task automatic issue(input logic [NR-1:0] r, output logic [NR-1:0] g);
    bus.req = r;
    g = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.gnt != '0) begin
        g = bus.gnt;
        break;
      end
    end
    bus.req = '0;
  endtask

  // Bounded wait for done; n = cycles from the call, extra counts stray
  // gnt/lcd_write pulses or lcd_data changes seen on the way.
  task automatic wait_done(output int n, output logic [NR-1:0] d, output logic e, output int extra);
    logic [DW-1:0] data0;
    data0 = bus.lcd_data;
    n = 0; d = '0; e = 1'b0; extra = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      n++;
      if (bus.lcd_write || bus.gnt != '0) extra++;
      if (bus.lcd_data !== data0) extra++;
      if (bus.done != '0) begin
        d = bus.done;
        e = bus.err;
        break;
      end
    end
  endtask

  function automatic int oh_idx(input logic [NR-1:0] v);
    int r;
    r = -1;
    for (int j = 0; j < NR; j++) if (v[j]) r = j;
    return r;
  endfunction

  logic [DW-1:0] exp_data [NR];
  int            exp_order [6];

  initial begin
    logic [NR-1:0] g, d;
    logic          e;
    int            n, extra, k, acc;
    logic [NR-1:0] mask;
    int            order [6];

    exp_data[0] = 18'h12345;
    exp_data[1] = 18'h0F00F;
    exp_data[2] = 18'h1C7C0;
    exp_data[3] = 18'h3A5A5;
    exp_order   = '{0, 1, 2, 3, 0, 1};

    bus.req          = '0;
    bus.req_data     = {exp_data[3], exp_data[2], exp_data[1], exp_data[0]};
    bus.req_line     = 4'b0100;
    bus.req_set_line = 4'b0110;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check_zero("rst");
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(bus.busy), 32'h0);

    // Single request from requester 2
    issue(4'b0100, g);
    check("t1_gnt",     32'(g),                32'h4);
    check("t1_write",   32'(bus.lcd_write),    32'h1);
    check("t1_data",    32'(bus.lcd_data),     32'h1C7C0);
    check("t1_line",    32'(bus.lcd_line),     32'h1);
    check("t1_setline", 32'(bus.lcd_set_line), 32'h1);
    wait_done(n, d, e, extra);
    // ISSUE at I, WAIT_HI I+1, WAIT_LO I+2..I+4, GAP I+5..I+6
    check("t1_latency", 32'(n),     32'd6);
    check("t1_done",    32'(d),     32'h4);
    check("t1_err",     32'(e),     32'h0);
    check("t1_stable",  32'(extra), 32'h0);
    tick();
    check("t1_idle_busy", 32'(bus.busy),     32'h0);
    check("t1_idle_data", 32'(bus.lcd_data), 32'h1C7C0);

    // All four requesting continuously after a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req = 4'b1111;
    k = 0;
    for (int i = 0; i < 200 && k < 6; i++) begin
      tick();
      if (bus.gnt != '0) begin
        order[k] = oh_idx(bus.gnt);
        check($sformatf("rr_data_%0d", k), 32'(bus.lcd_data), 32'(exp_data[order[k]]));
        k++;
      end
    end
    bus.req = '0;
    check("rr_count", 32'(k), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("rr_order_%0d", i), 32'(order[i]), 32'(exp_order[i]));
    for (int w = 0; w < 3; w++) begin
      mask = '0;
      for (int j = 0; j < 4; j++) if (order[w+j] >= 0 && order[w+j] < NR) mask[order[w+j]] = 1'b1;
      check($sformatf("rr_window_%0d", w), 32'(mask), 32'hF);
    end
    wait_done(n, d, e, extra);
    check("rr_last_done", 32'(d), 32'h2);

    // Pointer wrap: 3 served leaves the pointer at 0
    issue(4'b1000, g);
    check("wrap_gnt3", 32'(g), 32'h8);
    wait_done(n, d, e, extra);
    check("wrap_done3", 32'(d), 32'h8);
    issue(4'b1001, g);
    check("wrap_gnt0",  32'(g),            32'h1);
    check("wrap_data0", 32'(bus.lcd_data), 32'h12345);
    wait_done(n, d, e, extra);
    check("wrap_done0", 32'(d), 32'h1);

    // Timeout with enableOut stuck low
    stuck = 1'b1;
    issue(4'b0010, g);
    check("to_gnt", 32'(g), 32'h2);
    wait_done(n, d, e, extra);
    // WAIT_HI I+1..I+16, GAP I+17..I+18
    check("to_latency", 32'(n), 32'd18);
    check("to_done",    32'(d), 32'h2);
    check("to_err",     32'(e), 32'h1);
    stuck = 1'b0;
    issue(4'b0100, g);
    check("to_next_gnt", 32'(g), 32'h4);
    wait_done(n, d, e, extra);
    check("to_next_latency", 32'(n), 32'd6);
    check("to_next_done",    32'(d), 32'h4);
    check("to_next_err",     32'(e), 32'h0);

    // Reset while in WAIT_LO
    en_len = 6;
    issue(4'b0001, g);
    check("rmid_gnt", 32'(g), 32'h1);
    tick();
    tick();
    check("rmid_busy", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    tick();
    check_zero("rmid");
    rst = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done != '0 || bus.err) acc++;
    end
    check("rmid_no_done", 32'(acc), 32'h0);
    en_len = 3;
    issue(4'b0011, g);
    check("rmid_after_gnt", 32'(g), 32'h1);
    wait_done(n, d, e, extra);
    check("rmid_after_done", 32'(d), 32'h1);

    // Withdrawn request: req[1] pulsed for one cycle while busy
    issue(4'b0001, g);
    check("wd_gnt0", 32'(g), 32'h1);
    tick();
    bus.req = 4'b0010;
    tick();
    bus.req = '0;
    wait_done(n, d, e, extra);
    check("wd_latency",  32'(n),     32'd4);
    check("wd_done",     32'(d),     32'h1);
    check("wd_no_gnt",   32'(extra), 32'h0);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.busy || bus.gnt != '0) acc++;
    end
    check("wd_idle", 32'(acc), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
